// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared definitions for the instruction fetch queue: bus widths, constants,
// FSM state encodings, the default FIFO depth and the FIFO entry layout.
// Optional feature macro used by the top: IFQ_BYPASS_EN.
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        ChipEnable  = 1'b1;
  localparam int          IfqDepth    = 4;

  typedef enum logic [1:0] {
    IfqIdle = 2'd0,
    IfqBusy = 2'd1,
    IfqDrop = 2'd2
  } ifq_state_e;

  // One buffered fetch: the address it was fetched from and the returned word.
  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
// DEPTH-entry {pc, instruction} FIFO for the fetch queue. Wrapping read/write
// pointers plus an explicit occupancy count so full and empty are unambiguous.
// The head is presented combinationally and forced to zero when empty.
//
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset (clears pointers and count)
//   i_push   : write i_wdata at the tail (caller guarantees a free slot)
//   i_pop    : retire the head entry
//   i_clear  : drop every entry; overrides push and pop
//   i_wdata  : entry to write
//   o_head   : head entry (zero when empty)
//   o_valid  : FIFO holds at least one entry
//   o_count  : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IfqDepth,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_clear,
  input  ifq_entry_t  i_wdata,
  output ifq_entry_t  o_head,
  output logic        o_valid,
  output logic [PW:0] o_count
);

  ifq_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push & ~i_clear;
  // Never retire from an empty queue, even if the caller asks to.
  assign w_do_pop  = i_pop & ~i_clear & (r_count != '0);

  // Storage needs no reset: the head is masked by o_valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Fetch stage between pc_reg and ID. Issues at most one instruction-ROM
// request at a time, buffers returned {pc, instruction} pairs in ifq_fifo and
// hands them to ID over valid/ready. Stalls pc_reg when no request can be
// issued and discards in-flight and buffered fetches on a branch flush.
//
// Optional feature: define IFQ_BYPASS_EN to forward a response straight to ID
// in its ack cycle when the FIFO is empty and ID is ready (1-cycle latency).
// Without it every response goes through the FIFO (2-cycle latency).
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   pc_i, ce_i    : fetch address and fetch enable from pc_reg
//   stall_o       : hold pc this cycle (combinational, 0 during a flush)
//   flush_i       : branch taken, kill every fetch
//   rom_addr_o/req_o, rom_ack_i/data_i : ROM request/response handshake
//   inst_o, inst_pc_o, inst_valid_o, id_ready_i : head entry to ID
// -----------------------------------------------------------------------------
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IfqDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic                   ce_i,
  output logic                   stall_o,
  input  logic                   flush_i,
  output logic [InstAddrBus-1:0] rom_addr_o,
  output logic                   rom_req_o,
  input  logic                   rom_ack_i,
  input  logic [InstBus-1:0]     rom_data_i,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_pc_o,
  output logic                   inst_valid_o,
  input  logic                   id_ready_i
);

  localparam int PW = $clog2(DEPTH);

  ifq_state_e             r_state;
  ifq_state_e             w_state_next;
  logic                   r_rom_req;
  logic                   w_rom_req_next;
  logic [InstAddrBus-1:0] r_rom_addr;
  logic [InstAddrBus-1:0] w_rom_addr_next;

  ifq_entry_t  w_fifo_head;
  ifq_entry_t  w_fifo_wdata;
  logic        w_fifo_valid;
  logic [PW:0] w_fifo_count;

  logic          w_fetch_en;
  logic          w_ack_busy;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic [PW+1:0] w_level_next;
  logic          w_room;
  logic          w_issue;

  assign w_fetch_en = (ce_i == ChipEnable);
  // Only a response to a live request counts; acks in DROP are discarded.
  assign w_ack_busy = rom_ack_i & (r_state == IfqBusy);

`ifdef IFQ_BYPASS_EN
  assign w_bypass = ~w_fifo_valid & w_ack_busy & ~flush_i & id_ready_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_ack_busy & ~flush_i & ~w_bypass;
  assign w_pop  = w_fifo_valid & id_ready_i;

  // Occupancy after this cycle's push/pop; one extra bit so DEPTH+1 fits.
  assign w_level_next = {1'b0, w_fifo_count} + {{(PW+1){1'b0}}, w_push}
                        - {{(PW+1){1'b0}}, w_pop};
  assign w_room       = (w_level_next < (PW+2)'(DEPTH));

  // A new request may go out from IDLE, or back-to-back on the ack of the
  // current one; DROP must first absorb its stale response.
  assign w_issue = w_fetch_en & ~flush_i & w_room &
                   ((r_state == IfqIdle) | w_ack_busy);

  assign stall_o = w_fetch_en & ~flush_i & ~w_issue;

  always_comb begin
    w_state_next    = r_state;
    w_rom_req_next  = r_rom_req;
    w_rom_addr_next = r_rom_addr;

    case (r_state)
      IfqIdle: begin
        if (w_issue) w_state_next = IfqBusy;
      end
      IfqBusy: begin
        if (rom_ack_i) begin
          // issue is already 0 under a flush, so flush+ack lands in IDLE.
          w_state_next = w_issue ? IfqBusy : IfqIdle;
        end else if (flush_i) begin
          // Request stays up until the ROM answers; that answer is discarded.
          w_state_next = IfqDrop;
        end
      end
      IfqDrop: begin
        if (rom_ack_i) w_state_next = IfqIdle;
      end
      default: w_state_next = IfqIdle;
    endcase

    if (w_issue) begin
      w_rom_req_next  = 1'b1;
      w_rom_addr_next = pc_i;
    end else if (rom_ack_i && (r_state != IfqIdle)) begin
      w_rom_req_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IfqIdle;
      r_rom_req  <= 1'b0;
      r_rom_addr <= ZeroWord;
    end else begin
      r_state    <= w_state_next;
      r_rom_req  <= w_rom_req_next;
      r_rom_addr <= w_rom_addr_next;
    end
  end

  assign w_fifo_wdata.pc   = r_rom_addr;
  assign w_fifo_wdata.inst = rom_data_i;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_wdata (w_fifo_wdata),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign rom_req_o    = r_rom_req;
  assign rom_addr_o   = r_rom_addr;
  assign inst_valid_o = w_fifo_valid | w_bypass;
  assign inst_o       = w_bypass ? rom_data_i : w_fifo_head.inst;
  assign inst_pc_o    = w_bypass ? r_rom_addr : w_fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed bench for inst_fetch_queue (DEPTH 4). The ROM answers with
// addr ^ 0xDEAD0000 whenever the bench raises ack. Inputs change 1 time unit
// after each rising edge; outputs are checked 2 units after the edge.
// Works with or without IFQ_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        ce;
  logic        stall;
  logic        flush;
  logic [31:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_data = rom_ack ? (rom_addr ^ 32'hDEAD_0000) : 32'h0;

  inst_fetch_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .pc_i         (pc),
    .ce_i         (ce),
    .stall_o      (stall),
    .flush_i      (flush),
    .rom_addr_o   (rom_addr),
    .rom_req_o    (rom_req),
    .rom_ack_i    (rom_ack),
    .rom_data_i   (rom_data),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid),
    .id_ready_i   (ready)
  );

  function automatic logic [31:0] iw(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drv(input logic c, input logic [31:0] p, input logic a,
                     input logic r, input logic f);
    ce = c; pc = p; rom_ack = a; ready = r; flush = f;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    $display("reset state");
    chk("rst_req",   {31'b0, rom_req},    32'h0);
    chk("rst_addr",  rom_addr,            32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst",  inst,                32'h0);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_stall", {31'b0, stall},      32'h0);

    // ---- streaming: ROM acks one cycle after req, ID always ready ----
    nxt; rst_n = 1'b1;
    drv(1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    $display("stream: first issue pc 0x0");
    chk("s_a_stall", {31'b0, stall}, 32'h0);

    nxt; drv(1'b1, 32'h4, 1'b1, 1'b1, 1'b0);
    $display("stream: ack pc 0x0");
    chk("s_b_req",   {31'b0, rom_req},    32'h1);
    chk("s_b_addr",  rom_addr,            32'h0);
    chk("s_b_valid", {31'b0, inst_valid}, BYP ? 32'h1 : 32'h0);
    chk("s_b_inst",  inst,                BYP ? iw(32'h0) : 32'h0);
    chk("s_b_stall", {31'b0, stall},      32'h0);

    nxt; drv(1'b1, 32'h8, 1'b1, 1'b1, 1'b0);
    $display("stream: ack pc 0x4");
    chk("s_c_addr",  rom_addr,            32'h4);
    chk("s_c_valid", {31'b0, inst_valid}, 32'h1);
    chk("s_c_pc",    inst_pc,             BYP ? 32'h4 : 32'h0);
    chk("s_c_inst",  inst,                BYP ? iw(32'h4) : iw(32'h0));

    nxt; drv(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    $display("stream: ack pc 0x8");
    chk("s_d_addr", rom_addr, 32'h8);
    chk("s_d_pc",   inst_pc,  BYP ? 32'h8 : 32'h4);

    nxt; drv(1'b0, 32'h10, 1'b1, 1'b1, 1'b0);
    $display("stream: ce low, ack pc 0xc");
    chk("s_e_addr",  rom_addr,       32'hC);
    chk("s_e_pc",    inst_pc,        BYP ? 32'hC : 32'h8);
    chk("s_e_stall", {31'b0, stall}, 32'h0);

    nxt; drv(1'b0, 32'h10, 1'b0, 1'b1, 1'b0);
    $display("stream: drain");
    chk("s_f_req",   {31'b0, rom_req},    32'h0);
    chk("s_f_valid", {31'b0, inst_valid}, BYP ? 32'h0 : 32'h1);
    chk("s_f_pc",    inst_pc,             BYP ? 32'h0 : 32'hC);

    nxt; drv(1'b0, 32'h10, 1'b0, 1'b1, 1'b0);
    $display("stream: empty");
    chk("s_g_valid", {31'b0, inst_valid}, 32'h0);
    chk("s_g_inst",  inst,                32'h0);
    chk("s_g_pc",    inst_pc,             32'h0);

    // ---- back-pressure: ID not ready, FIFO fills ----
    nxt; drv(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    $display("bp: issue pc 0x20");
    chk("b1_stall", {31'b0, stall},   32'h0);
    chk("b1_req",   {31'b0, rom_req}, 32'h0);

    nxt; drv(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
    $display("bp: ack pc 0x20");
    chk("b2_addr",  rom_addr,            32'h20);
    chk("b2_valid", {31'b0, inst_valid}, 32'h0);
    chk("b2_stall", {31'b0, stall},      32'h0);

    nxt; drv(1'b1, 32'h28, 1'b1, 1'b0, 1'b0);
    $display("bp: ack pc 0x24");
    chk("b3_addr", rom_addr, 32'h24);
    chk("b3_pc",   inst_pc,  32'h20);

    nxt; drv(1'b1, 32'h2C, 1'b1, 1'b0, 1'b0);
    $display("bp: ack pc 0x28");
    chk("b4_addr", rom_addr, 32'h28);

    nxt; drv(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
    $display("bp: ack pc 0x2c fills fifo");
    chk("b5_addr",  rom_addr,       32'h2C);
    chk("b5_stall", {31'b0, stall}, 32'h1);

    nxt; drv(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    $display("bp: full, holding");
    chk("b6_req",   {31'b0, rom_req}, 32'h0);
    chk("b6_stall", {31'b0, stall},   32'h1);
    chk("b6_pc",    inst_pc,          32'h20);

    nxt; drv(1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
    $display("bp: full, holding");
    chk("b7_req",   {31'b0, rom_req}, 32'h0);
    chk("b7_stall", {31'b0, stall},   32'h1);

    nxt; drv(1'b1, 32'h30, 1'b0, 1'b1, 1'b0);
    $display("bp: one pop, one issue pc 0x30");
    chk("b8_stall", {31'b0, stall}, 32'h0);
    chk("b8_pc",    inst_pc,        32'h20);
    chk("b8_inst",  inst,           iw(32'h20));

    // ---- slow ROM: acks on the third request cycle ----
    nxt; drv(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    $display("slow: waiting pc 0x30");
    chk("w1_req",   {31'b0, rom_req}, 32'h1);
    chk("w1_addr",  rom_addr,         32'h30);
    chk("w1_stall", {31'b0, stall},   32'h1);
    chk("w1_pc",    inst_pc,          32'h24);

    nxt; drv(1'b1, 32'h34, 1'b0, 1'b0, 1'b0);
    $display("slow: waiting pc 0x30");
    chk("w2_req",   {31'b0, rom_req}, 32'h1);
    chk("w2_addr",  rom_addr,         32'h30);
    chk("w2_stall", {31'b0, stall},   32'h1);

    nxt; drv(1'b1, 32'h34, 1'b1, 1'b1, 1'b0);
    $display("slow: ack pc 0x30 with pop");
    chk("w3_addr",  rom_addr,       32'h30);
    chk("w3_stall", {31'b0, stall}, 32'h0);
    chk("w3_pc",    inst_pc,        32'h24);

    // ---- wrap and simultaneous push/pop ----
    nxt; drv(1'b1, 32'h38, 1'b1, 1'b0, 1'b0);
    $display("wrap: ack pc 0x34 fills fifo");
    chk("p1_addr",  rom_addr,       32'h34);
    chk("p1_stall", {31'b0, stall}, 32'h1);
    chk("p1_pc",    inst_pc,        32'h28);

    nxt; drv(1'b1, 32'h38, 1'b0, 1'b1, 1'b0);
    $display("wrap: pop from full, issue pc 0x38");
    chk("p2_req",   {31'b0, rom_req}, 32'h0);
    chk("p2_pc",    inst_pc,          32'h28);
    chk("p2_inst",  inst,             iw(32'h28));
    chk("p2_stall", {31'b0, stall},   32'h0);

    nxt; drv(1'b1, 32'h3C, 1'b1, 1'b1, 1'b0);
    $display("wrap: ack pc 0x38 with pop");
    chk("p3_addr",  rom_addr,       32'h38);
    chk("p3_pc",    inst_pc,        32'h2C);
    chk("p3_stall", {31'b0, stall}, 32'h0);

    // ---- flush while BUSY without ack, target 0x100 ----
    nxt; drv(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    $display("flush: busy pc 0x3c, no ack");
    chk("f1_stall", {31'b0, stall}, 32'h0);
    chk("f1_pc",    inst_pc,        32'h30);
    chk("f1_addr",  rom_addr,       32'h3C);

    nxt; drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    $display("flush: drop state");
    chk("f2_valid", {31'b0, inst_valid}, 32'h0);
    chk("f2_pc",    inst_pc,             32'h0);
    chk("f2_req",   {31'b0, rom_req},    32'h1);
    chk("f2_addr",  rom_addr,            32'h3C);
    chk("f2_stall", {31'b0, stall},      32'h1);

    nxt; drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    $display("flush: late ack discarded");
    chk("f3_valid", {31'b0, inst_valid}, 32'h0);
    chk("f3_stall", {31'b0, stall},      32'h1);

    nxt; drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    $display("flush: issue pc 0x100");
    chk("f4_req",   {31'b0, rom_req},    32'h0);
    chk("f4_valid", {31'b0, inst_valid}, 32'h0);
    chk("f4_stall", {31'b0, stall},      32'h0);

    nxt; drv(1'b0, 32'h104, 1'b1, 1'b0, 1'b0);
    $display("flush: ack pc 0x100, ce low");
    chk("f5_req",   {31'b0, rom_req},    32'h1);
    chk("f5_addr",  rom_addr,            32'h100);
    chk("f5_valid", {31'b0, inst_valid}, 32'h0);

    nxt; drv(1'b0, 32'h104, 1'b0, 1'b1, 1'b0);
    $display("flush: consume pc 0x100");
    chk("f6_req",   {31'b0, rom_req},    32'h0);
    chk("f6_valid", {31'b0, inst_valid}, 32'h1);
    chk("f6_pc",    inst_pc,             32'h100);
    chk("f6_inst",  inst,                iw(32'h100));

    nxt; drv(1'b0, 32'h104, 1'b0, 1'b1, 1'b0);
    $display("flush: empty again");
    chk("f7_valid", {31'b0, inst_valid}, 32'h0);

    // ---- asynchronous reset in the middle of a request ----
    nxt; drv(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    $display("rst: issue pc 0x200");
    chk("r1_stall", {31'b0, stall}, 32'h0);

    nxt; drv(1'b0, 32'h204, 1'b0, 1'b0, 1'b0);
    $display("rst: request pending, assert reset");
    chk("r2_req",  {31'b0, rom_req}, 32'h1);
    chk("r2_addr", rom_addr,         32'h200);
    rst_n = 1'b0;
    #1;
    chk("r3_req",   {31'b0, rom_req},    32'h0);
    chk("r3_addr",  rom_addr,            32'h0);
    chk("r3_valid", {31'b0, inst_valid}, 32'h0);

    nxt; rst_n = 1'b1;
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
